// File: rtl/bf_run_ctrl.sv
// bf_run_ctrl: run-control scheduler for the brainfuck CPU core.
// Issues single-cycle cpu_ce pulses at a programmable rate. It supports
// run, halt, step and set-divider commands, stalls on UART waits and
// stops for good at end of program.
// Optional breakpoint support is enabled by defining BF_RUN_CTRL_BREAK_EN.
module bf_run_ctrl #(
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DIV_DEFAULT = 31,
  parameter int unsigned COUNT_W     = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  input  logic [1:0]         cmd_op,
  input  logic [DIV_W-1:0]   cmd_div,
  input  logic               cpu_wait,
  input  logic               cpu_done,
`ifdef BF_RUN_CTRL_BREAK_EN
  input  logic [COUNT_W-1:0] bp_addr,
  input  logic               bp_en,
  output logic               bp_hit,
`endif
  output logic               cpu_ce,
  output logic [1:0]         state,
  output logic [COUNT_W-1:0] step_count,
  output logic [3:0]         leds_dbg
);

  typedef enum logic [1:0] {
    StHalt = 2'd0,
    StRun  = 2'd1,
    StStep = 2'd2,
    StDone = 2'd3
  } state_e;

  localparam logic [1:0] OpHalt   = 2'd0;
  localparam logic [1:0] OpRun    = 2'd1;
  localparam logic [1:0] OpStep   = 2'd2;
  localparam logic [1:0] OpSetDiv = 2'd3;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_reg_q, div_reg_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [COUNT_W-1:0] step_count_q, step_count_d;
  logic               cpu_ce_q;
  logic               fire;

  logic cmd_halt, cmd_run, cmd_step, cmd_setdiv;
  assign cmd_halt   = cmd_valid && (cmd_op == OpHalt);
  assign cmd_run    = cmd_valid && (cmd_op == OpRun);
  assign cmd_step   = cmd_valid && (cmd_op == OpStep);
  assign cmd_setdiv = cmd_valid && (cmd_op == OpSetDiv);

`ifdef BF_RUN_CTRL_BREAK_EN
  logic               bp_hit_q, bp_hit_d;
  logic [COUNT_W-1:0] count_after_fire;
  // The pulse already on cpu_ce is not yet in step_count, so add it too.
  assign count_after_fire = step_count_q + COUNT_W'(cpu_ce_q) + COUNT_W'(1);
`endif

  // Next-state, divider and fire decision.
  always_comb begin
    state_d   = state_q;
    div_reg_d = div_reg_q;
    div_cnt_d = div_cnt_q;
    fire      = 1'b0;
`ifdef BF_RUN_CTRL_BREAK_EN
    bp_hit_d  = 1'b0;
`endif
    unique case (state_q)
      StHalt: begin
        div_cnt_d = '0;
        if (cmd_run) begin
          state_d = StRun;
        end else if (cmd_step) begin
          // A step with no wait pending fires right away and stays in HALT.
          if (!cpu_wait) fire = 1'b1;
          else           state_d = StStep;
        end
      end
      StRun: begin
        if (div_cnt_q == div_reg_q) begin
          if (!cpu_wait) begin
            fire      = 1'b1;
            div_cnt_d = '0;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
        if (cmd_halt) begin
          state_d   = StHalt;
          div_cnt_d = '0;
        end
      end
      StStep: begin
        if (cmd_halt) begin
          state_d = StHalt;
        end else if (!cpu_wait) begin
          fire    = 1'b1;
          state_d = StHalt;
        end
      end
      StDone: begin
        div_cnt_d = '0;
      end
    endcase

    if (cmd_setdiv) begin
      div_reg_d = cmd_div;
      div_cnt_d = '0;
    end

`ifdef BF_RUN_CTRL_BREAK_EN
    bp_hit_d = fire && bp_en && (count_after_fire == bp_addr);
    if (bp_hit_d) state_d = StHalt;
`endif

    // End of program beats every command and any fire in the same cycle.
    if (cpu_done) begin
      state_d = StDone;
      fire    = 1'b0;
`ifdef BF_RUN_CTRL_BREAK_EN
      bp_hit_d = 1'b0;
`endif
    end
  end

  // Saturating count of issued pulses.
  always_comb begin
    step_count_d = step_count_q;
    if (cpu_ce_q && (step_count_q != '1)) step_count_d = step_count_q + COUNT_W'(1);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StHalt;
      div_reg_q    <= DIV_W'(DIV_DEFAULT);
      div_cnt_q    <= '0;
      step_count_q <= '0;
      cpu_ce_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_reg_q    <= div_reg_d;
      div_cnt_q    <= div_cnt_d;
      step_count_q <= step_count_d;
      cpu_ce_q     <= fire;
    end
  end

`ifdef BF_RUN_CTRL_BREAK_EN
  // Breakpoint flag, aligned with the pulse that triggered it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bp_hit_q <= 1'b0;
    else        bp_hit_q <= bp_hit_d;
  end
  assign bp_hit = bp_hit_q;
`endif

  assign cpu_ce     = cpu_ce_q;
  assign state      = state_q;
  assign step_count = step_count_q;
  assign leds_dbg   = {state_q, cpu_wait, cpu_ce_q};

endmodule
